// File: rtl/guess_pkg.sv
// Shared encodings for the guess_range_game core: FSM states, hint results and the LFSR step.
package guess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_SHOW = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_LOW  = 2'd1,
        RES_HIGH = 2'd2,
        RES_HIT  = 2'd3
    } result_t;

    // Taps 8,6,5,4 of an 8-bit Fibonacci LFSR (maximal length).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: two-flop synchroniser, stability counter, and a one-cycle rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    import guess_pkg::*;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= level;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/guess_range_game.sv
// Number-guessing game core: debounced buttons, narrowing hint window, attempt limit and best score.
module guess_range_game #(
    parameter int          MAX_VAL         = 10,
    parameter int          VAL_W           = 7,
    parameter int          MAX_TRIES       = 7,
    parameter int          ATT_W           = 4,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          SHOW_CYCLES     = 100000000,
    parameter int          END_CYCLES      = 150000000,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_submit,
    output logic [2:0]       state_o,
    output logic [VAL_W-1:0] guess_o,
    output logic [VAL_W-1:0] lo_o,
    output logic [VAL_W-1:0] hi_o,
    output logic [ATT_W-1:0] attempts_o,
    output logic [1:0]       result_o,
    output logic [VAL_W-1:0] target_o,
    output logic [ATT_W-1:0] best_o
);
    import guess_pkg::*;

    localparam int HOLD_MAX = (SHOW_CYCLES > END_CYCLES) ? SHOW_CYCLES : END_CYCLES;
    localparam int TMR_W    = $clog2(HOLD_MAX + 1);

    localparam logic [VAL_W-1:0] ONE       = VAL_W'(1);
    localparam logic [VAL_W-1:0] MAX_V     = VAL_W'(MAX_VAL);
    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] END_LAST  = TMR_W'(END_CYCLES - 1);

    logic             start_p;
    logic             inc_p;
    logic             dec_p;
    logic             submit_p;
    logic [3:0]       unused_levels;

    state_t           state;
    result_t          result;
    result_t          verdict;
    logic [VAL_W-1:0] guess;
    logic [VAL_W-1:0] lo;
    logic [VAL_W-1:0] hi;
    logic [VAL_W-1:0] target;
    logic [VAL_W-1:0] target_shown;
    logic [VAL_W-1:0] target_next;
    logic [VAL_W-1:0] guess_up;
    logic [VAL_W-1:0] guess_dn;
    logic [ATT_W-1:0] attempts;
    logic [ATT_W-1:0] att_next;
    logic [ATT_W-1:0] best;
    logic [TMR_W-1:0] timer;
    logic [7:0]       lfsr;
    logic             limit_hit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk(clk), .reset(reset), .raw(btn_start), .level(unused_levels[0]), .rise(start_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
        .clk(clk), .reset(reset), .raw(btn_inc), .level(unused_levels[1]), .rise(inc_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
        .clk(clk), .reset(reset), .raw(btn_dec), .level(unused_levels[2]), .rise(dec_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_submit (
        .clk(clk), .reset(reset), .raw(btn_submit), .level(unused_levels[3]), .rise(submit_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Target is drawn from the LFSR value present on the cycle the start press is accepted.
    assign target_next = VAL_W'(({24'd0, lfsr} % 32'(MAX_VAL)) + 32'd1);

    assign guess_up  = guess + ONE;
    assign guess_dn  = guess - ONE;
    assign att_next  = (&attempts) ? attempts : attempts + ATT_W'(1);
    assign limit_hit = (MAX_TRIES != 0) && (att_next == ATT_W'(MAX_TRIES));

    always_comb begin
        verdict = RES_HIT;
        if (guess < target) begin
            verdict = RES_LOW;
        end else if (guess > target) begin
            verdict = RES_HIGH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            result       <= RES_NONE;
            guess        <= ONE;
            lo           <= ONE;
            hi           <= MAX_V;
            attempts     <= '0;
            best         <= '0;
            target       <= '0;
            target_shown <= '0;
            timer        <= '0;
        end else if (start_p) begin
            // Start restarts from any state and discards whatever hold was running.
            state        <= ST_PLAY;
            result       <= RES_NONE;
            guess        <= ONE;
            lo           <= ONE;
            hi           <= MAX_V;
            attempts     <= '0;
            target       <= target_next;
            target_shown <= '0;
            timer        <= '0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (submit_p) begin
                        attempts <= att_next;
                        result   <= verdict;
                        timer    <= '0;
                        if (verdict == RES_HIT) begin
                            state        <= ST_WIN;
                            target_shown <= target;
                            if (best == '0 || att_next < best) begin
                                best <= att_next;
                            end
                        end else if (limit_hit) begin
                            state        <= ST_LOSE;
                            target_shown <= target;
                        end else begin
                            state <= ST_SHOW;
                        end
                    end else if (inc_p && !dec_p) begin
                        guess <= (guess == hi) ? lo : guess_up;
                    end else if (dec_p && !inc_p) begin
                        guess <= (guess == lo) ? hi : guess_dn;
                    end
                end
                ST_SHOW: begin
                    if (timer == SHOW_LAST) begin
                        // The hint moves the window bound just past the guess, keeping lo<=target<=hi.
                        timer  <= '0;
                        result <= RES_NONE;
                        state  <= ST_PLAY;
                        if (result == RES_LOW) begin
                            lo    <= guess_up;
                            guess <= guess_up;
                        end else begin
                            hi    <= guess_dn;
                            guess <= guess_dn;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (timer == END_LAST) begin
                        timer        <= '0;
                        target_shown <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o    = state;
    assign result_o   = result;
    assign guess_o    = guess;
    assign lo_o       = lo;
    assign hi_o       = hi;
    assign attempts_o = attempts;
    assign target_o   = target_shown;
    assign best_o     = best;

endmodule
